// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// Module  : pc_sequencer_pkg
// Brief   : Shared NPC operation encodings, reset text base and sequencer
//           state encodings for the fetch-stage PC sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

    localparam logic [1:0] NPC_PLUS4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH   = 2'b01;
    localparam logic [1:0] NPC_JUMP_IMM = 2'b10;
    localparam logic [1:0] NPC_JUMP_REG = 2'b11;

    localparam logic [31:0] TEXT_BASE_ADDRESS = 32'h0000_3000;

    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] S_BOOT  = 2'd0;
    localparam logic [STATE_W-1:0] S_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] S_FLUSH = 2'd2;
    localparam logic [STATE_W-1:0] S_HALT  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/npc_target_calc.sv
// ============================================================================
// Module  : npc_target_calc
// Brief   : Combinational redirect target from the redirecting instruction's
//           PC, immediate and register operand, plus a misalignment flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module npc_target_calc
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [1:0]      i_rd_op,
    input  logic [PC_W-1:0] i_rd_pc,
    input  logic [25:0]     i_imm26,
    input  logic [PC_W-1:0] i_addr32,
    output logic [PC_W-1:0] o_target,
    output logic            o_misalign
);

    logic [PC_W-1:0] w_p4;
    logic [PC_W-1:0] w_br_off;
    logic [PC_W-1:0] w_jimm;

    assign w_p4     = i_rd_pc + PC_W'(4);
    assign w_br_off = {{(PC_W-18){i_imm26[15]}}, i_imm26[15:0], 2'b00};
    // Jump-immediate keeps the upper region bits of PC+4
    assign w_jimm   = {w_p4[PC_W-1:28], i_imm26, 2'b00};

    always_comb begin
        o_target = w_p4;
        case (i_rd_op)
            NPC_PLUS4:    o_target = w_p4;
            NPC_BRANCH:   o_target = w_p4 + w_br_off;
            NPC_JUMP_IMM: o_target = w_jimm;
            NPC_JUMP_REG: o_target = i_addr32;
            default:      o_target = w_p4;
        endcase
    end

    assign o_misalign = |o_target[1:0];

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module  : pc_sequencer
// Brief   : Fetch-stage PC owner with imem valid/ready handshake, EX redirects
//           with a one-cycle flush bubble, halt and an accepted-fetch counter.
//           Optional exception entry / return enabled by NPC_EXC_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] TEXT_BASE  = PC_W'(TEXT_BASE_ADDRESS),
    parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(32'h0000_4180),
    parameter int              CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ready,
    output logic              if_valid,
    output logic [PC_W-1:0]   pc,
    input  logic              rd_valid,
    input  logic [1:0]        rd_op,
    input  logic [PC_W-1:0]   rd_pc,
    input  logic [25:0]       imm26,
    input  logic [PC_W-1:0]   addr32,
    input  logic              halt,
`ifdef NPC_EXC_EN
    input  logic              exc_req,
    input  logic [PC_W-1:0]   exc_pc,
    input  logic              eret,
    output logic [PC_W-1:0]   epc,
`endif
    output logic              flush,
    output logic              addr_err,
    output logic [CNT_W-1:0]  fetch_cnt
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic [PC_W-1:0]    r_pc;
    logic               r_flush;
    logic               r_addr_err;
    logic [CNT_W-1:0]   r_fetch_cnt;

    logic [PC_W-1:0]    w_target;
    logic               w_misalign;
    logic               w_active;
    logic               w_exc;
    logic               w_eret;
    logic               w_halt;
    logic               w_redir;
    logic               w_accept;
    logic               w_enter_flush;

    npc_target_calc #(
        .PC_W       (PC_W)
    ) u_target (
        .i_rd_op    (rd_op),
        .i_rd_pc    (rd_pc),
        .i_imm26    (imm26),
        .i_addr32   (addr32),
        .o_target   (w_target),
        .o_misalign (w_misalign)
    );

    assign w_active = (r_state == S_RUN) || (r_state == S_FLUSH);

`ifdef NPC_EXC_EN
    logic [PC_W-1:0] r_epc;
    assign w_exc  = exc_req && (r_state != S_HALT);
    assign w_eret = eret && !exc_req && (r_state != S_HALT);
    assign epc    = r_epc;
`else
    // EXC_VECTOR has no consumer when exception entry is compiled out
    logic w_unused_exc_vector;
    assign w_exc               = 1'b0;
    assign w_eret              = 1'b0;
    assign w_unused_exc_vector = ^EXC_VECTOR;
`endif

    // Priority chain: exception > eret > halt > redirect > accept
    assign w_halt        = halt && w_active && !w_exc && !w_eret;
    assign w_redir       = rd_valid && w_active && !w_exc && !w_eret && !halt;
    assign w_accept      = (r_state == S_RUN) && if_ready && !w_exc && !w_eret
                           && !halt && !rd_valid;
    assign w_enter_flush = w_exc || w_eret || w_redir;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_enter_flush) begin
            w_state_next = S_FLUSH;
        end else if (w_halt) begin
            w_state_next = S_HALT;
        end else begin
            case (r_state)
                S_BOOT:  w_state_next = S_RUN;
                S_RUN:   w_state_next = S_RUN;
                S_FLUSH: w_state_next = S_RUN;
                S_HALT:  w_state_next = S_HALT;
                default: w_state_next = S_BOOT;
            endcase
        end
    end

    always_comb begin
        if_valid  = (r_state == S_RUN);
        pc        = r_pc;
        flush     = r_flush;
        addr_err  = r_addr_err;
        fetch_cnt = r_fetch_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= TEXT_BASE;
            r_flush     <= 1'b0;
            r_addr_err  <= 1'b0;
            r_fetch_cnt <= '0;
`ifdef NPC_EXC_EN
            r_epc       <= '0;
`endif
        end else begin
            r_flush <= w_enter_flush;
`ifdef NPC_EXC_EN
            if (w_exc) begin
                r_epc <= exc_pc;
            end
`endif
            if (w_exc) begin
                r_pc <= EXC_VECTOR;
            end else if (w_eret) begin
`ifdef NPC_EXC_EN
                r_pc <= r_epc;
`endif
            end else if (w_redir) begin
                r_pc <= {w_target[PC_W-1:2], 2'b00};
                if (w_misalign) begin
                    r_addr_err <= 1'b1;
                end
            end else if (w_accept) begin
                r_pc        <= r_pc + PC_W'(4);
                r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire
